// File: rtl/cva6_cluster_dispatch.sv
// rtl/cva6_cluster_dispatch.sv - Fork CVA6 requests to all Ara clusters and join their responses
module cva6_cluster_dispatch #(
  parameter int NrClusters     = 4,
  parameter int ReqWidth       = 128,
  parameter int RespWidth      = 64,
  parameter int MaxOutstanding = 8,
  localparam int CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [ReqWidth-1:0]             req_data_i,
  output logic                            resp_valid_o,
  input  logic                            resp_ready_i,
  output logic [RespWidth-1:0]            resp_data_o,
  output logic                            resp_error_o,
  output logic [NrClusters-1:0]           clu_req_valid_o,
  input  logic [NrClusters-1:0]           clu_req_ready_i,
  output logic [ReqWidth-1:0]             clu_req_data_o,
  input  logic [NrClusters-1:0]           clu_resp_valid_i,
  output logic [NrClusters-1:0]           clu_resp_ready_o,
  input  logic [NrClusters*RespWidth-1:0] clu_resp_data_i,
  input  logic [NrClusters-1:0]           clu_resp_error_i,
  output logic [CntW-1:0]                 outstanding_o,
  output logic                            idle_o,
  output logic                            proto_err_o
);

  typedef enum logic {GATHER, PRESENT} state_e;

  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  state_e                 state_q, state_d;
  logic [NrClusters-1:0]  acc_q;
  logic [NrClusters-1:0]  col_q;
  logic [NrClusters-1:0]  req_hs;
  logic [NrClusters-1:0]  gather_hs;
  logic                   err_q;
  logic [RespWidth-1:0]   data_q;
  logic [CntW-1:0]        cnt_q;
  logic                   proto_err_q;
  logic                   credit;
  logic                   req_done;
  logic                   resp_done;
  logic                   unused_resp_data;

  // Only cluster 0 supplies the returned payload; the other slices are ignored.
  assign unused_resp_data = ^clu_resp_data_i[NrClusters*RespWidth-1:RespWidth];

  // A new request may only be forked while there is room for its response.
  assign credit          = cnt_q < MaxCnt;
  assign clu_req_valid_o = {NrClusters{req_valid_i & credit}} & ~acc_q;
  assign req_hs          = clu_req_valid_o & clu_req_ready_i;
  assign req_ready_o     = req_valid_i & credit & (&(acc_q | req_hs));
  assign req_done        = req_ready_o;
  assign clu_req_data_o  = req_data_i;

  // Clusters still owed a response may hand it over while gathering.
  assign gather_hs = (state_q == GATHER) ? (clu_resp_valid_i & ~col_q) : '0;

  assign resp_data_o   = data_q;
  assign resp_error_o  = err_q;
  assign outstanding_o = cnt_q;
  assign proto_err_o   = proto_err_q;
  assign idle_o        = (cnt_q == '0) && (state_q == GATHER) && (col_q == '0) && (acc_q == '0);

  // Remember which clusters already took the current request so none sees it twice.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else if (req_done) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_q | req_hs;
    end
  end

  // Gather FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= GATHER;
    end else begin
      state_q <= state_d;
    end
  end

  // Gather FSM: collect one response per cluster, then present the merged result.
  always_comb begin
    state_d          = state_q;
    clu_resp_ready_o = '0;
    resp_valid_o     = 1'b0;
    resp_done        = 1'b0;
    case (state_q)
      GATHER: begin
        clu_resp_ready_o = ~col_q;
        if (&(col_q | gather_hs)) begin
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) begin
          resp_done = 1'b1;
          state_d   = GATHER;
        end
      end
      default: state_d = GATHER;
    endcase
  end

  // Collected-cluster mask, merged error and cluster 0 payload.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q  <= '0;
      err_q  <= 1'b0;
      data_q <= '0;
    end else if (resp_done) begin
      col_q <= '0;
      err_q <= 1'b0;
    end else begin
      col_q <= col_q | gather_hs;
      err_q <= err_q | (|(gather_hs & clu_resp_error_i));
      if (gather_hs[0]) begin
        data_q <= clu_resp_data_i[RespWidth-1:0];
      end
    end
  end

  // In-flight counter; a response with nothing in flight is flagged and never underflows.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (resp_done && (cnt_q == '0)) begin
        proto_err_q <= 1'b1;
      end
      if (req_done && !resp_done) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!req_done && resp_done && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: doc/cva6_cluster_dispatch.md
CVA6_CLUSTER_DISPATCH -- requirements
Module: cva6_cluster_dispatch

Parameters
REQ-001 The block SHALL provide parameter NrClusters, default 4, the number of Ara clusters receiving each request (at least 2).
REQ-002 The block SHALL provide parameter ReqWidth, default 128, the width in bits of the request payload.
REQ-003 The block SHALL provide parameter RespWidth, default 64, the width in bits of the response payload.
REQ-004 The block SHALL provide parameter MaxOutstanding, default 8, the maximum number of accepted requests without a returned response; CntW = $clog2(MaxOutstanding+1).

Interface
REQ-005 The block SHALL have these ports (clock and reset first):
 clk_i  in  1  clock; all state changes on its rising edge
 rst_i  in  1  reset; asynchronous, active-high
 req_valid_i  in  1  CVA6 request valid
 req_ready_o  out  1  request accepted by all clusters
 req_data_i  in  ReqWidth  request payload; held stable while req_valid_i=1
 resp_valid_o  out  1  merged response valid
 resp_ready_i  in  1  CVA6 response ready
 resp_data_o  out  RespWidth  response payload (cluster 0 data)
 resp_error_o  out  1  OR of all cluster error bits
 clu_req_valid_o  out  NrClusters  per-cluster request valid
 clu_req_ready_i  in  NrClusters  per-cluster request ready
 clu_req_data_o  out  ReqWidth  broadcast payload, equal to req_data_i
 clu_resp_valid_i  in  NrClusters  per-cluster response valid
 clu_resp_ready_o  out  NrClusters  per-cluster response ready
 clu_resp_data_i  in  NrClusters*RespWidth  cluster i payload at slice [i*RespWidth +: RespWidth]
 clu_resp_error_i  in  NrClusters  per-cluster error
 outstanding_o  out  CntW  number of in-flight requests
 idle_o  out  1  no activity and no in-flight requests
 proto_err_o  out  1  sticky flag for a protocol violation

Function
REQ-006 Request fork: clu_req_valid_o[i] SHALL be req_valid_i & ~acc_q[i] & credit, where credit = (outstanding < MaxOutstanding).
REQ-007 A cluster handshake (clu_req_valid_o[i] & clu_req_ready_i[i]) SHALL set acc_q[i] at the next edge.
REQ-008 req_ready_o SHALL assert combinationally in the cycle where acc_q | (clu_req_valid_o & clu_req_ready_i) is all-ones; in that cycle acc_q SHALL clear.
REQ-009 Clusters SHALL accept a request in any order and over any number of cycles; no cluster SHALL see the same request twice.
REQ-010 When credit=0, every clu_req_valid_o SHALL be 0 and req_ready_o SHALL be 0; acc_q SHALL be retained.
REQ-011 Response gather uses FSM GATHER/PRESENT and register col_q[NrClusters]; reset state is GATHER.
REQ-012 In GATHER, clu_resp_ready_o[i] SHALL equal ~col_q[i]. A handshake sets col_q[i] and ORs clu_resp_error_i[i] into err_q. A handshake of cluster 0 SHALL also capture its data slice into data_q.
REQ-013 When col_q | handshakes is all-ones, the FSM SHALL move to PRESENT at the next edge (1-cycle latency from the last cluster response).
REQ-014 In PRESENT, the block SHALL drive resp_valid_o=1, resp_data_o=data_q, resp_error_o=err_q and clu_resp_ready_o=0.
REQ-015 In PRESENT, resp_ready_i=1 SHALL return the FSM to GATHER and clear col_q and err_q. resp_valid_o SHALL stay asserted and the payload stable until that handshake.
REQ-016 The outstanding counter SHALL increment on each upstream request handshake and decrement on each upstream response handshake. On simultaneous increment and decrement it SHALL be unchanged.
REQ-017 If a response completes with outstanding=0, the counter SHALL hold at 0 and proto_err_o SHALL set and stay set until reset.
REQ-018 idle_o SHALL be (outstanding=0) & GATHER & (col_q=0) & (acc_q=0).
REQ-019 The request and response paths SHALL be independent; handshakes on both in the same cycle SHALL be legal.

Reset
REQ-020 While rst_i=1: acc_q=0, col_q=0, err_q=0, data_q=0, FSM=GATHER, counter=0, proto_err_o=0.
REQ-021 While rst_i=1 the outputs SHALL be: resp_valid_o=0, clu_resp_ready_o all-ones, outstanding_o=0, idle_o=1. req_ready_o SHALL be 0 whenever req_valid_i=0.
REQ-022 Reset asserted mid-transaction SHALL discard partial acceptance and partial gather state immediately; no response SHALL be produced for in-flight requests.

Verification
REQ-023 NrClusters=4, all clu_req_ready_i=1, req_valid_i pulse -> req_ready_o=1 the same cycle, outstanding_o=1 next cycle.
REQ-024 clu_req_ready_i=0001, then 0100, then 1010 -> each cluster is handshaked once; req_ready_o=1 only in the third cycle.
REQ-025 Cluster responses arrive in order 3,0,2,1; cluster 0 data=0xA5, cluster 2 error=1 -> one cycle after cluster 1: resp_valid_o=1, resp_data_o=0xA5, resp_error_o=1.
REQ-026 8 requests accepted with no response -> the 9th gets clu_req_valid_o=0000. A response handshake then reopens credit, and the 9th request is accepted in the following cycle.
REQ-027 Response completion with outstanding_o=0 -> proto_err_o=1 (sticky), outstanding_o stays 0.
REQ-028 rst_i asserted with acc_q=0011 and col_q=0101 -> next observation shows both cleared, idle_o=1 and resp_valid_o=0.
